// File: rtl/fp16_norm_arb_pkg.sv
// rtl/fp16_norm_arb_pkg.sv - shared constants and response record for the FP16 fraction normalizer
package fp16_norm_arb_pkg;

    localparam int FRAC_W          = 10;
    localparam int EXP_ADJ_W       = 5;
    localparam int LOD_IDX_OFFSET  = 2;
    localparam int NORM_SHIFT_BASE = 12;
    localparam int LOD_IDX_W       = 4;
    localparam int RSP_ID_MAX_W    = 3;

    typedef struct packed {
        logic [RSP_ID_MAX_W-1:0] id;
        logic [FRAC_W-1:0]       frac;
        logic [EXP_ADJ_W-1:0]    exp_adj;
        logic                    zero;
    } norm_rsp_t;

endpackage

// File: rtl/fp16_norm_arb_lod10.sv
// rtl/fp16_norm_arb_lod10.sv - combinational 10-bit leading-one detector
// idx = msb_position + LOD_IDX_OFFSET, or 0 when the input is zero.
module fp16_norm_arb_lod10
    import fp16_norm_arb_pkg::*;
(
    input  logic [FRAC_W-1:0]    frac,
    output logic [LOD_IDX_W-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int p = 0; p < FRAC_W; p++) begin
            if (|(frac & (FRAC_W'(1) << p))) begin
                idx = LOD_IDX_W'(p + LOD_IDX_OFFSET);
            end
        end
    end

endmodule

// File: rtl/fp16_norm_arb.sv
// rtl/fp16_norm_arb.sv - round-robin shared FP16 subnormal fraction normalizer, two-stage pipeline
// Optional: NORM_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module fp16_norm_arb
    import fp16_norm_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*FRAC_W-1:0]   req_frac,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [FRAC_W-1:0]        rsp_frac,
    output logic [EXP_ADJ_W-1:0]     rsp_exp_adj,
    output logic                     rsp_zero
);

    localparam logic [ID_W:0] NREQ_V = (ID_W+1)'(NREQ);

    logic [ID_W-1:0]      rr_ptr, rr_base, rr_next, grant_id;
    logic [ID_W:0]        sum, inc;
    logic [NREQ-1:0]      cand, rot;
    logic                 grant_any, accept;
    logic                 s1_v, s1_free, s1_adv, s2_free;
    logic [ID_W-1:0]      s1_id;
    logic [FRAC_W-1:0]    s1_frac, frac_sel, norm_frac;
    logic [LOD_IDX_W-1:0] lod_idx, shift;
    norm_rsp_t            rsp_q;
    logic                 id_hi_unused;

    // Rotate the candidate mask so bit k is requester (rr_base + k) mod NREQ.
    always_comb begin
        cand    = req_valid;
        rr_base = rr_ptr;
`ifdef NORM_ARB_PRIO0_EN
        cand[0] = 1'b0;
        if (rr_ptr == '0) rr_base = ID_W'(1);
`endif
        rot       = NREQ'({cand, cand} >> rr_base);
        grant_any = 1'b0;
        grant_id  = '0;
        sum       = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (|(rot & (NREQ'(1) << k))) begin
                grant_any = 1'b1;
                sum       = {1'b0, rr_base} + (ID_W+1)'(k);
                if (sum >= NREQ_V) sum = sum - NREQ_V;
                grant_id  = sum[ID_W-1:0];
            end
        end
`ifdef NORM_ARB_PRIO0_EN
        if (req_valid[0]) begin
            grant_any = 1'b1;
            grant_id  = '0;
        end
`endif
    end

    always_comb begin
        inc     = {1'b0, grant_id} + (ID_W+1)'(1);
        rr_next = (inc == NREQ_V) ? '0 : inc[ID_W-1:0];
`ifdef NORM_ARB_PRIO0_EN
        if (inc == NREQ_V) rr_next = ID_W'(1);
        if (grant_id == '0) rr_next = rr_ptr;
`endif
    end

    assign s2_free   = !rsp_valid || rsp_ready;
    assign s1_adv    = s1_v && s2_free;
    assign s1_free   = !s1_v || s1_adv;
    assign accept    = grant_any && s1_free && !rst;
    assign req_ready = accept ? (NREQ'(1) << grant_id) : '0;
    assign frac_sel  = FRAC_W'(req_frac >> (grant_id * FRAC_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            s1_v    <= 1'b0;
            s1_id   <= '0;
            s1_frac <= '0;
        end else if (accept) begin
            rr_ptr  <= rr_next;
            s1_v    <= 1'b1;
            s1_id   <= grant_id;
            s1_frac <= frac_sel;
        end else if (s1_adv) begin
            s1_v    <= 1'b0;
        end
    end

    fp16_norm_arb_lod10 u_lod10 (
        .frac (s1_frac),
        .idx  (lod_idx)
    );

    // Shifting by 12-idx pushes the leading one just past bit 9, dropping the hidden bit.
    assign shift     = LOD_IDX_W'(NORM_SHIFT_BASE) - lod_idx;
    assign norm_frac = s1_frac << shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else if (s1_adv) begin
            rsp_valid <= 1'b1;
            if (lod_idx == '0) begin
                rsp_q <= '{id: RSP_ID_MAX_W'(s1_id), frac: '0, exp_adj: '0, zero: 1'b1};
            end else begin
                rsp_q <= '{id: RSP_ID_MAX_W'(s1_id), frac: norm_frac,
                           exp_adj: EXP_ADJ_W'(1) - EXP_ADJ_W'(shift), zero: 1'b0};
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_id       = ID_W'(rsp_q.id);
    assign rsp_frac     = rsp_q.frac;
    assign rsp_exp_adj  = rsp_q.exp_adj;
    assign rsp_zero     = rsp_q.zero;
    assign id_hi_unused = ^rsp_q.id;

endmodule

// File: tb/tb_fp16_norm_arb.sv
// tb/tb_fp16_norm_arb.sv - self-checking bench: vector table, directed corner sequences, random traffic vs reference model
module tb_fp16_norm_arb;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*10-1:0] req_frac;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [9:0]        rsp_frac;
    logic [4:0]        rsp_exp_adj;
    logic              rsp_zero;

    always #5 clk = ~clk;

    fp16_norm_arb #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_frac    (req_frac),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_frac    (rsp_frac),
        .rsp_exp_adj (rsp_exp_adj),
        .rsp_zero    (rsp_zero)
    );

    typedef struct {
        logic [1:0] id;
        logic [9:0] frac;
        logic [4:0] adj;
        logic       zero;
    } rsp_t;

    typedef struct {
        logic [9:0] frac_in;
        logic [9:0] frac;
        logic [4:0] adj;
        logic       zero;
    } vec_t;

    int   nvec = 0;
    int   nerr = 0;
    rsp_t exp_q[$];
    int   ptr_m = 0;
    logic [NREQ-1:0] acc_mask = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Normalization straight from the arithmetic definition.
    function automatic rsp_t ref_norm(input int id, input logic [9:0] f);
        rsp_t e;
        int   v, p, sh;
        e.id = 2'(id);
        v = int'(f);
        if (v == 0) begin
            e.frac = '0; e.adj = '0; e.zero = 1'b1;
        end else begin
            p  = $clog2(v + 1) - 1;
            sh = 10 - p;
            e.frac = 10'((v << sh) & 'h3FF);
            e.adj  = 5'(1 - sh);
            e.zero = 1'b0;
        end
        return e;
    endfunction

    function automatic bit vbit(input logic [NREQ-1:0] v, input int i);
        return ((v >> i) & NREQ'(1)) != '0;
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        int base;
`ifdef NORM_ARB_PRIO0_EN
        if (vbit(v, 0)) return 0;
        base = (p == 0) ? 1 : p;
        for (int k = 0; k < NREQ-1; k++)
            if (vbit(v, 1 + ((base - 1 + k) % (NREQ-1)))) return 1 + ((base - 1 + k) % (NREQ-1));
`else
        base = p;
        for (int k = 0; k < NREQ; k++)
            if (vbit(v, (base + k) % NREQ)) return (base + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic int model_next(input int g, input int p);
`ifdef NORM_ARB_PRIO0_EN
        if (g == 0) return p;
        return (g + 1 == NREQ) ? 1 : g + 1;
`else
        return (g + 1) % NREQ;
`endif
    endfunction

    // Monitor: grant choice, readiness, response order/content, output stability under stall.
    logic       stall = 1'b0;
    logic [1:0] h_id;
    logic [9:0] h_frac;
    logic [4:0] h_adj;
    logic       h_zero;
    int         g_m, ai;
    bit         exp_any;
    rsp_t       e_m;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ptr_m    = 0;
            stall    = 1'b0;
            acc_mask = '0;
        end else begin
            if (stall) begin
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_out", {rsp_id, rsp_frac, rsp_exp_adj, rsp_zero}, {h_id, h_frac, h_adj, h_zero});
            end
            g_m     = model_grant(req_valid, ptr_m);
            exp_any = (req_valid != '0) && (exp_q.size() < 2 || rsp_ready);
            chk("req_ready", 32'(req_ready), exp_any ? (32'd1 << g_m) : 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL rsp_unexpected: got id %0d with nothing outstanding at %0t", rsp_id, $time);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e_m.id));
                    chk("rsp_frac", 32'(rsp_frac), 32'(e_m.frac));
                    chk("rsp_exp_adj", 32'(rsp_exp_adj), 32'(e_m.adj));
                    chk("rsp_zero", 32'(rsp_zero), 32'(e_m.zero));
                end
            end
            acc_mask = req_valid & req_ready;
            if (acc_mask != '0) begin
                ai = 0;
                for (int i = 0; i < NREQ; i++) if (vbit(acc_mask, i)) ai = i;
                exp_q.push_back(ref_norm(ai, 10'(req_frac >> (10 * ai))));
                ptr_m = model_next(ai, ptr_m);
            end
            stall  = rsp_valid && !rsp_ready;
            h_id   = rsp_id;
            h_frac = rsp_frac;
            h_adj  = rsp_exp_adj;
            h_zero = rsp_zero;
        end
    end

    function automatic logic [9:0] rand_frac();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return '0;
        if (r == 1) return 10'(1) << $urandom_range(0, 9);
        return 10'($urandom);
    endfunction

    vec_t tbl[7];
    logic [NREQ-1:0]    cur_v;
    logic [NREQ*10-1:0] cur_f;
    int                 acc;

    initial begin
        tbl[0] = '{10'h001, 10'h000, 5'h17, 1'b0};
        tbl[1] = '{10'h200, 10'h000, 5'h00, 1'b0};
        tbl[2] = '{10'h0A5, 10'h128, 5'h1E, 1'b0};
        tbl[3] = '{10'h000, 10'h000, 5'h00, 1'b1};
        tbl[4] = '{10'h3FF, 10'h3FE, 5'h00, 1'b0};
        tbl[5] = '{10'h010, 10'h000, 5'h1B, 1'b0};
        tbl[6] = '{10'h155, 10'h154, 5'h1F, 1'b0};

        rst       = 1'b1;
        req_valid = '1;
        req_frac  = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_frac, rsp_exp_adj, rsp_zero}, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;

        // Single requester, table of fractions, two-cycle latency.
        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            req_valid = 4'b0001;
            req_frac  = 40'(tbl[v].frac_in);
            @(negedge clk);
            chk("tbl_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk("tbl_latency_early", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk("tbl_valid", 32'(rsp_valid), 32'd1);
            chk("tbl_out", {rsp_id, rsp_frac, rsp_exp_adj, rsp_zero},
                {2'd0, tbl[v].frac, tbl[v].adj, tbl[v].zero});
        end

        // Backpressure: two accepts fill S1/S2, then the arbiter stalls.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '1;
        req_frac  = {10'h00F, 10'h0A5, 10'h001, 10'h200};
        acc = 0;
        repeat (5) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) acc++;
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        @(negedge clk);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Reset with both stages full.
        #1 rsp_ready = 1'b0;
        req_valid = '1;
        repeat (4) @(negedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd0);
        chk("async_rst_out", {rsp_id, rsp_frac, rsp_exp_adj, rsp_zero}, 32'd0);
        req_valid = 4'b1100;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);

        // All requesters valid from a fresh reset: round-robin at full rate.
        #1 rst = 1'b1;
        req_valid = '1;
        req_frac  = {10'h008, 10'h004, 10'h002, 10'h001};
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
`ifdef NORM_ARB_PRIO0_EN
            chk("rr_grant", 32'(req_ready), 32'd1);
            if (k >= 2) chk("rr_rsp_id", {31'(rsp_valid), 1'b0} | 32'(rsp_id), 32'd2);
`else
            chk("rr_grant", 32'(req_ready), 32'd1 << (k % 4));
            if (k >= 2) chk("rr_rsp_id", {28'd0, rsp_valid, 1'b0, rsp_id}, {28'd0, 1'b1, 1'b0, 2'((k - 2) % 4)});
`endif
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        // Random traffic; requesters hold frac while waiting and may withdraw.
        cur_v = '0;
        cur_f = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (cur_v[i] && !acc_mask[i]) begin
                    if ($urandom_range(0, 9) == 0) cur_v[i] = 1'b0;
                end else begin
                    cur_v[i] = ($urandom_range(0, 99) < 60);
                    cur_f[i*10 +: 10] = rand_frac();
                end
            end
            req_valid = cur_v;
            req_frac  = cur_f;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
